// File: rtl/string_char_streamer.sv
// string_char_streamer: streams a packed ASCII string out one byte per valid/ready handshake.
// Optional macro NUL_SKIP_EN builds a SCAN state that skips leading 8'h00 padding.
module string_char_streamer #(
    parameter int MAXCHARS = 80,
    parameter int CNTW     = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*MAXCHARS-1:0] str_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ch_valid,
    input  logic                  ch_ready,
    output logic [7:0]            ch_data,
    output logic [CNTW-1:0]       len_out
);

    localparam int W = 8 * MAXCHARS;
    localparam logic [CNTW-1:0] LAST = CNTW'(MAXCHARS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_FIN
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_str,   w_str_nxt;
    logic [CNTW-1:0] r_idx,   w_idx_nxt;
    logic [CNTW-1:0] r_cnt,   w_cnt_nxt;
    logic [CNTW-1:0] r_len,   w_len_nxt;
    logic [7:0]      r_data,  w_data_nxt;
    logic            r_valid, w_valid_nxt;

    // The capture register shifts left as bytes are consumed, so the byte
    // at r_idx is always the top byte and the following one sits below it.
    logic [7:0] w_top;
    logic [7:0] w_next;
    logic       w_hs;
    logic       w_last;

    assign w_top  = r_str[W-1 -: 8];
    assign w_next = r_str[W-9 -: 8];
    assign w_hs   = r_valid & ch_ready;
    assign w_last = (r_idx == LAST);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_str   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_str   <= w_str_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state and datapath update; SEND loads its first byte itself when
    // entered without a presented character
    always_comb begin
        w_state_nxt = r_state;
        w_str_nxt   = r_str;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_str_nxt = str_in;
                    w_idx_nxt = '0;
                    w_cnt_nxt = '0;
`ifdef NUL_SKIP_EN
                    w_state_nxt = S_SCAN;
`else
                    w_state_nxt = S_SEND;
`endif
                end
            end
`ifdef NUL_SKIP_EN
            S_SCAN: begin
                if (w_top != 8'h00) begin
                    w_data_nxt  = w_top;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_SEND;
                end else if (w_last) begin
                    w_len_nxt   = '0;
                    w_state_nxt = S_FIN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                    w_str_nxt = r_str << 8;
                end
            end
`endif
            S_SEND: begin
                if (!r_valid) begin
                    w_data_nxt  = w_top;
                    w_valid_nxt = 1'b1;
                end else if (w_hs) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_len_nxt   = r_cnt + 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_str_nxt  = r_str << 8;
                        w_data_nxt = w_next;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy     = (r_state == S_SCAN) || (r_state == S_SEND);
    assign done     = (r_state == S_FIN);
    assign ch_valid = r_valid;
    assign ch_data  = r_data;
    assign len_out  = r_len;

endmodule

// File: tb/tb_string_char_streamer.sv
// tb_string_char_streamer: randomized self-checking bench for string_char_streamer.
// Expected byte streams come from a per-index walk of the string, independent of the RTL.
module tb_string_char_streamer;

    localparam int MC = 80;
    localparam int W  = 8 * MC;

    typedef byte unsigned bq_t[$];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] str_in;
    logic         busy;
    logic         done;
    logic         ch_valid;
    logic         ch_ready;
    logic [7:0]   ch_data;
    logic [6:0]   len_out;

    int n_cmp  = 0;
    int n_fail = 0;

    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    string_char_streamer #(.MAXCHARS(MC), .CNTW(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .str_in   (str_in),
        .busy     (busy),
        .done     (done),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_data  (ch_data),
        .len_out  (len_out)
    );

    always #5 clk = ~clk;

    // Bytes a consumer should see: character 0 is the leftmost byte;
    // with skipping, bytes before the first non-NUL are dropped.
    function automatic bq_t model(input logic [W-1:0] s);
        bq_t q;
        bit  seen;
        logic [7:0] b;
        q = {};
`ifdef NUL_SKIP_EN
        seen = 1'b0;
`else
        seen = 1'b1;
`endif
        for (int i = 0; i < MC; i++) begin
            b = s[W-1-8*i -: 8];
            if (b != 8'h00) seen = 1'b1;
            if (seen) q.push_back(b);
        end
        return q;
    endfunction

    // Cycles from the start edge to the first ch_valid
    function automatic int exp_first(input bq_t q);
        if (q.size() == 0) return -1;
`ifdef NUL_SKIP_EN
        return 2 + (MC - q.size());
`else
        return 2;
`endif
    endfunction

    function automatic int qdiff(input bq_t a, input bq_t b);
        int d;
        if (a.size() != b.size()) return 1000 + a.size();
        d = 0;
        for (int i = 0; i < a.size(); i++)
            if (a[i] != b[i]) d++;
        return d;
    endfunction

    // Start one run and observe it at negedges; c counts cycles after the start edge
    task automatic run(input logic [W-1:0] s, input logic [W-1:0] s_after,
                       input bit hold, input int mode, input int tail,
                       output bq_t got, output int first, output int dcyc,
                       output int ndone, output int stall_err,
                       output logic [6:0] len, output logic b_at_d,
                       output logic v_at_d);
        bit pst;
        logic [7:0] pd;
        got = {};
        first = -1;
        dcyc = -1;
        ndone = 0;
        stall_err = 0;
        len = 'x;
        b_at_d = 'x;
        v_at_d = 'x;
        pst = 1'b0;
        pd = 8'h00;
        @(negedge clk);
        str_in = s;
        start = 1'b1;
        ch_ready = 1'b0;
        @(negedge clk);
        start = hold;
        str_in = s_after;
        for (int c = 1; c < 2000; c++) begin
            if (c > 1) @(negedge clk);
            if (ch_valid && first < 0) first = c;
            case (mode)
                0: ch_ready = 1'b1;
                1: ch_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (first < 0) ch_ready = 1'($urandom_range(0, 1));
                    else ch_ready = (c - first < 6) ? pat[c-first] : 1'b1;
                end
            endcase
            if (pst && ch_data !== pd) stall_err++;
            pst = ch_valid && !ch_ready;
            pd = ch_data;
            if (ch_valid && ch_ready) got.push_back(ch_data);
            if (done) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c;
                    len = len_out;
                    b_at_d = busy;
                    v_at_d = ch_valid;
                end
            end
            if (dcyc >= 0 && c >= dcyc + tail) break;
        end
        ch_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ch_ready = 1'b0;
        str_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b%b exp 00", busy, done);
        end
        n_cmp++;
        if (ch_valid !== 1'b0 || ch_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ch: got v=%b d=%h exp v=0 d=00", ch_valid, ch_data);
        end
        n_cmp++;
        if (len_out !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_len: got %0d exp 0", len_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full check of one run with ready held high
    task automatic test_stream(input string name, input logic [W-1:0] s);
        bq_t got, exp;
        int first, dcyc, ndone, serr, ef, ed;
        logic [6:0] len;
        logic bd, vd;
        exp = model(s);
        ef = exp_first(exp);
        ed = (exp.size() == 0) ? MC + 1 : ef + exp.size();
        run(s, s, 1'b0, 0, 3, got, first, dcyc, ndone, serr, len, bd, vd);
        n_cmp++;
        if (qdiff(got, exp) != 0) begin
            n_fail++;
            $display("FAIL %s_bytes: got %0d bytes exp %0d (diff %0d)",
                     name, got.size(), exp.size(), qdiff(got, exp));
        end
        n_cmp++;
        if (len !== 7'(exp.size())) begin
            n_fail++;
            $display("FAIL %s_len: got %0d exp %0d", name, len, exp.size());
        end
        n_cmp++;
        if (first != ef) begin
            n_fail++;
            $display("FAIL %s_first_valid: got %0d exp %0d", name, first, ef);
        end
        n_cmp++;
        if (dcyc != ed) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d exp %0d", name, dcyc, ed);
        end
        n_cmp++;
        if (ndone != 1 || bd !== 1'b0 || vd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got n=%0d busy=%b v=%b exp n=1 busy=0 v=0",
                     name, ndone, bd, vd);
        end
        n_cmp++;
        if (serr != 0) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d exp 0", name, serr);
        end
    endtask

    task automatic test_literal();
        logic [W-1:0] s;
        s = "hello, world /*";
        test_stream("literal", s);
    endtask

    task automatic test_all_zero();
        test_stream("zero", '0);
    endtask

    task automatic test_full_width();
        logic [W-1:0] s;
        for (int i = 0; i < MC; i++) s[8*i +: 8] = 8'($urandom_range(1, 255));
        test_stream("full", s);
    endtask

    task automatic test_backpressure();
        bq_t got, exp;
        int first, dcyc, ndone, serr, ed, hs, k;
        logic [6:0] len;
        logic bd, vd;
        logic [W-1:0] s;
        s = "abc";
        exp = model(s);
        run(s, s, 1'b0, 2, 3, got, first, dcyc, ndone, serr, len, bd, vd);
        hs = 0;
        k = 0;
        while (hs < exp.size()) begin
            if (k >= 6 || pat[k]) hs++;
            k++;
        end
        ed = first + k;
        n_cmp++;
        if (qdiff(got, exp) != 0) begin
            n_fail++;
            $display("FAIL bp_bytes: got %0d bytes exp %0d", got.size(), exp.size());
        end
        n_cmp++;
        if (serr != 0) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got %0d changes exp 0", serr);
        end
        n_cmp++;
        if (dcyc != ed || ndone != 1) begin
            n_fail++;
            $display("FAIL bp_done: got c=%0d n=%0d exp c=%0d n=1", dcyc, ndone, ed);
        end
        n_cmp++;
        if (len !== 7'(exp.size())) begin
            n_fail++;
            $display("FAIL bp_len: got %0d exp %0d", len, exp.size());
        end
    endtask

    task automatic test_random();
        bq_t got, exp;
        int first, dcyc, ndone, serr, n;
        logic [6:0] len;
        logic bd, vd;
        logic [W-1:0] s;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, MC);
            s = '0;
            for (int i = 0; i < n; i++) begin
                if (i == 0) s[8*(n-1) +: 8] = 8'($urandom_range(1, 255));
                else if ($urandom_range(0, 7) == 0) s[8*(n-1-i) +: 8] = 8'h00;
                else s[8*(n-1-i) +: 8] = 8'($urandom_range(0, 255));
            end
            exp = model(s);
            run(s, s, 1'b0, 1, 2, got, first, dcyc, ndone, serr, len, bd, vd);
            n_cmp++;
            if (qdiff(got, exp) != 0 || len !== 7'(exp.size())) begin
                n_fail++;
                $display("FAIL rand%0d: got %0d bytes len %0d exp %0d (diff %0d)",
                         it, got.size(), len, exp.size(), qdiff(got, exp));
            end
            n_cmp++;
            if (ndone != 1 || serr != 0 || first != exp_first(exp)) begin
                n_fail++;
                $display("FAIL rand%0d_ctl: got n=%0d stall=%0d first=%0d exp 1 0 %0d",
                         it, ndone, serr, first, exp_first(exp));
            end
        end
    endtask

    task automatic test_start_busy();
        bq_t got, exp1, exp2, got2;
        int first, dcyc, ndone, serr, nd2;
        logic [6:0] len;
        logic bd, vd;
        logic [W-1:0] s1, s2;
        s1 = "first";
        s2 = "second!";
        exp1 = model(s1);
        exp2 = model(s2);
        run(s1, s2, 1'b1, 0, 0, got, first, dcyc, ndone, serr, len, bd, vd);
        n_cmp++;
        if (qdiff(got, exp1) != 0) begin
            n_fail++;
            $display("FAIL sb_capture: got %0d bytes exp %0d (diff %0d)",
                     got.size(), exp1.size(), qdiff(got, exp1));
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_idle_gap: got busy=%b done=%b exp 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_restart: got busy=%b exp 1", busy);
        end
        got2 = {};
        nd2 = 0;
        ch_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (ch_valid && ch_ready) got2.push_back(ch_data);
            if (done) begin
                nd2++;
                break;
            end
            @(negedge clk);
        end
        ch_ready = 1'b0;
        n_cmp++;
        if (qdiff(got2, exp2) != 0 || nd2 != 1) begin
            n_fail++;
            $display("FAIL sb_second: got %0d bytes done=%0d exp %0d bytes done=1",
                     got2.size(), nd2, exp2.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bq_t got, exp;
        int first, dcyc, ndone, serr, hs, nd;
        logic [6:0] len;
        logic bd, vd;
        logic [W-1:0] s;
        s = "abcdefgh";
        hs = 0;
        @(negedge clk);
        str_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ch_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (ch_valid && hs == 4) begin
                rst_n = 1'b0;
                break;
            end
            if (ch_valid && ch_ready) hs++;
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ch_ready = 1'b0;
        n_cmp++;
        if (ch_valid !== 1'b0 || busy !== 1'b0 || len_out !== 7'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b busy=%b len=%0d done=%b exp 0 0 0 0",
                     ch_valid, busy, len_out, done);
        end
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_cmp++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d exp 0", nd);
        end
        s = "xyz";
        exp = model(s);
        run(s, s, 1'b0, 0, 2, got, first, dcyc, ndone, serr, len, bd, vd);
        n_cmp++;
        if (qdiff(got, exp) != 0 || len !== 7'(exp.size()) || ndone != 1) begin
            n_fail++;
            $display("FAIL rst_rerun: got %0d bytes len %0d n=%0d exp %0d bytes",
                     got.size(), len, ndone, exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_literal();
        test_all_zero();
        test_full_width();
        test_backpressure();
        test_random();
        test_start_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
